fifo_wr_arbiter: RTL

Round-robin write arbiter that shares the single write port of `sync_fifo` among NREQ packet sources. Each source offers a (dst, data) word with a valid/ready handshake. The arbiter grants at most one source per cycle, stamps the source index into `src_in`, and drives `writep`/`dst_in`/`data_in` on the FIFO write side. It honours `fullp` so the FIFO never overflows, and it lets a granted source burst up to BURST consecutive words before the grant rotates.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/rr_pick.sv | 40 ++++
 rtl/fifo_wr_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared widths and helpers for the FIFO write-side arbitration slice.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int SRC_W  = 8;
  localparam int DST_W  = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  // Width of a binary requester index; never below one bit so that a
  // two-requester arbiter still has a usable index register.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request bit at or after start, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller gates the result with its own stall terms.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  // Walk start, start+1, ... modulo NREQ; the first requester seen wins.
  always_comb begin
    int            j;
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(start) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      idx = IW'(j);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one sync_fifo write port among NREQ sources.
// Latency: zero; the accept cycle is the FIFO write cycle (valid/fullp -> ready/writep).
// Backpressure: fullp blocks every grant; a stalled burst keeps owner and burst_cnt.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DST_W-1:0]  req_dst,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic                   fullp,
  output logic                   writep,
  output logic [SRC_W-1:0]       src_in,
  output logic [DST_W-1:0]       dst_in,
  output logic [DATA_W-1:0]      data_in,
  output logic [CNT_W-1:0]       burst_cnt
);

  localparam int              IW        = idx_width(NREQ);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NREQ - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST);

  logic [IW-1:0]   owner;
  logic            owner_vld;
  logic            hold;
  logic [IW-1:0]   scan_start;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            accept;
  logic            out_en;
  logic [NREQ-1:0] ready_int;

  // The owner keeps the grant only mid-burst: it must have been accepted at
  // least once under this grant and not yet used up its burst allowance.
  assign owner_vld = req_valid[owner];
  assign hold      = owner_vld && (burst_cnt != '0) && (burst_cnt < BURST_MAX);

  // Starting the scan at the owner itself makes the picker return the owner
  // while holding; otherwise the owner gets last priority.
  assign scan_start = hold ? owner
                           : ((owner == LAST_IDX) ? '0 : owner + IW'(1));

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req     (req_valid),
    .start   (scan_start),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // State advances on any accepted word. rstn is kept out of this term so the
  // asynchronous reset never feeds flop data; in reset the flops are cleared anyway.
  assign accept    = pick_any && !fullp;
  assign ready_int = accept ? pick_gnt : '0;

  // Outputs collapse to their reset values while rstn is low, without waiting for a clock.
  assign out_en    = rstn;
  assign req_ready = out_en ? ready_int : '0;
  assign writep    = |(req_valid & req_ready);

  // Route the granted requester's fields onto the FIFO write side; zero when idle.
  always_comb begin
    src_in  = '0;
    dst_in  = '0;
    data_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        src_in  = SRC_W'(i);
        dst_in  = req_dst[i*DST_W +: DST_W];
        data_in = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Track the grant owner and how many words it has pushed in the current burst.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner     <= LAST_IDX;
      burst_cnt <= '0;
    end else if (accept) begin
      if (hold) begin
        burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);
      end else begin
        owner     <= pick_idx;
        burst_cnt <= CNT_W'(1);
      end
    end else if (!owner_vld) begin
      // Owner went idle: the next win by anyone starts a fresh burst.
      burst_cnt <= '0;
    end
  end

endmodule
